nes_pad_responder: RTL and testbench
====================================

NES_PAD_RESPONDER -- requirements
Module: nes_pad_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of flops synchronizing latch_in and pulse_in (legal 2..4).
REQ-002 SHALL have parameter FILL_BIT, default 1'b0: line level driven after all 8 bits are shifted out (grounded serial-in of a real 4021).
REQ-003 SHALL have port clk, input, 1: the single block clock; all flops clock on the rising edge.
REQ-004 SHALL have port rst, input, 1: the reset; asynchronous and active-low.
REQ-005 SHALL have port latch_in, input, 1: console latch line, asynchronous to clk.
REQ-006 SHALL have port pulse_in, input, 1: console clock/pulse line, asynchronous to clk.
REQ-007 SHALL have port buttons_in, input, [0:7]: active-high pressed; index order A, B, Select, Start, Up, Down, Left, Right.
REQ-008 SHALL have port data_out, output, 1: serial line, active-low per button (pressed = 0).
REQ-009 SHALL have port bit_index, output, 4: pulse edges counted since the last latch fall, saturating at 8.
REQ-010 SHALL have port frame_done, output, 1: one-cycle pulse when the 8th bit has been consumed.
REQ-011 SHALL have port overrun, output, 1: sticky; a pulse edge arrived while bit_index == 8.
REQ-012 SHALL have port frame_count, output, 8: count of completed latch falls, wrapping 255 -> 0.

Function
REQ-013 SHALL act only on synchronized signals: latch_s and pulse_s, each delayed SYNC_STAGES clocks, with rise/fall strobes derived from one further registered copy.
REQ-014 SHALL implement states LOAD (latch_s high), SHIFT (latch_s low, bit_index < 8) and DRAINED (latch_s low, bit_index == 8).
REQ-015 SHALL, in LOAD, reload shift register sr = ~buttons_in every clock, hold bit_index = 0, and drive data_out = ~buttons_in[0], registered with 1-cycle latency.
REQ-016 SHALL, on a latch_s fall, freeze sr, enter SHIFT with bit_index = 0, and increment frame_count.
REQ-017 SHALL, on a pulse_s rise in SHIFT, shift sr toward data_out, insert FILL_BIT, increment bit_index, and update data_out on the following clock.
REQ-018 SHALL assert frame_done for exactly one clock when bit_index steps 7 -> 8, then enter DRAINED.
REQ-019 SHALL, in DRAINED, drive data_out = FILL_BIT; a pulse_s rise sets overrun and leaves bit_index at 8.
REQ-020 SHALL ignore pulse_s rises while latch_s is high; parallel load has priority, and overrun is not set.
REQ-021 SHALL, when a latch_s rise and a pulse_s rise occur in the same clock, perform LOAD only.
REQ-022 SHALL clear overrun on a latch_s rise.
REQ-023 SHALL ignore buttons_in changes during SHIFT and DRAINED; only the frozen snapshot is shifted.
REQ-024 SHALL, on a latch_s rise mid-frame (bit_index 1..7), abort the frame without asserting frame_done.
REQ-025 SHALL bound the worst-case delay from a pin edge to data_out update at SYNC_STAGES + 2 clocks.

Reset
REQ-026 SHALL, on rst low: sr = 8'hFF, data_out = 1, bit_index = 0, frame_done = 0, overrun = 0, frame_count = 0, and all synchronizer flops = 0.
REQ-027 SHALL, after rst release, treat the synchronizer pipeline as settled before detecting edges; no spurious edge is detected from reset values.
REQ-028 SHALL, on rst assertion mid-frame, discard the frame immediately and produce no frame_done.

Structure
REQ-029 SHALL take button index constants (BTN_A = 0 ... BTN_RIGHT = 7) and NES_BITS = 8 from shared package nes_pkg, also used by controller_nes.
REQ-030 SHALL instantiate sub-module sync_edge (synchronizer plus rise/fall strobes, parameter SYNC_STAGES) once for latch_in and once for pulse_in.

Verification
REQ-031 SHALL cover: buttons_in = 8'b1001_0000 (A and Start), latch high 12 us then low, 8 pulses -> data_out sequence 0,1,1,0,1,1,1,1; frame_done once; frame_count = 1.
REQ-032 SHALL cover: 10 pulses after latch fall -> bits 9 and 10 read FILL_BIT (0); overrun = 1; next latch rise clears overrun.
REQ-033 SHALL cover: buttons_in changed after latch fall -> shifted bits still match the pre-fall snapshot.
REQ-034 SHALL cover: latch re-raised after 3 pulses -> no frame_done; bit_index = 0; data_out follows ~buttons_in[0].
REQ-035 SHALL cover: rst pulsed low mid-frame -> data_out = 1, bit_index = 0, frame_count = 0; the next full frame is correct.
REQ-036 SHALL cover: frame_count wrap after 256 frames -> reads 0; pulse and latch rising in the same clock -> LOAD only, overrun stays 0.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared NES pad definitions: button bit order, frame length and responder states.
package nes_pkg;

  localparam int unsigned NES_BITS  = 8;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  typedef enum logic [1:0] {
    PAD_LOAD    = 2'd0,
    PAD_SHIFT   = 2'd1,
    PAD_DRAINED = 2'd2
  } pad_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, with rise/fall strobes
// taken against one further registered copy of the synchronized level.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sig_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stages;
  logic                   sig_d;

  // All flops clear to 0 so a low pin after reset never yields an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
      sig_d  <= 1'b0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], din};
      sig_d  <= stages[SYNC_STAGES-1];
    end
  end

  assign sig_s = stages[SYNC_STAGES-1];
  assign rise  = sig_s & ~sig_d;
  assign fall  = ~sig_s & sig_d;

endmodule

// File: rtl/nes_pad_responder.sv
// Emulates the 4021 shift register of an NES pad: parallel load while latch is
// high, then one button bit per console pulse on an active-low serial line.
module nes_pad_responder
  import nes_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        FILL_BIT    = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                latch_in,
  input  logic                pulse_in,
  input  logic [0:NES_BITS-1] buttons_in,
  output logic                data_out,
  output logic [3:0]          bit_index,
  output logic                frame_done,
  output logic                overrun,
  output logic [7:0]          frame_count
);

  localparam logic [3:0] LAST_IDX = 4'(NES_BITS - 1);

  logic latch_s, latch_rise, latch_fall;
  logic pulse_s, pulse_rise, pulse_fall;
  logic unused_pulse_level;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clk   (clk),
    .rst_n (rst),
    .din   (latch_in),
    .sig_s (latch_s),
    .rise  (latch_rise),
    .fall  (latch_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pulse_sync (
    .clk   (clk),
    .rst_n (rst),
    .din   (pulse_in),
    .sig_s (pulse_s),
    .rise  (pulse_rise),
    .fall  (pulse_fall)
  );

  assign unused_pulse_level = pulse_s ^ pulse_fall;

  pad_state_t          state, state_nx;
  logic [0:NES_BITS-1] sr, sr_nx;
  logic [3:0]          bit_nx;
  logic                dout_nx;
  logic                done_nx;
  logic                ovr_nx;
  logic [7:0]          cnt_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= PAD_SHIFT;
      sr          <= '1;
      data_out    <= 1'b1;
      bit_index   <= '0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_nx;
      sr          <= sr_nx;
      data_out    <= dout_nx;
      bit_index   <= bit_nx;
      frame_done  <= done_nx;
      overrun     <= ovr_nx;
      frame_count <= cnt_nx;
    end
  end

  // A high latch level wins over everything, which also makes a coincident
  // latch/pulse rise a pure load and aborts any partially shifted frame.
  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    bit_nx   = bit_index;
    dout_nx  = data_out;
    done_nx  = 1'b0;
    ovr_nx   = overrun;
    cnt_nx   = frame_count;

    if (latch_s) begin
      state_nx = PAD_LOAD;
      sr_nx    = ~buttons_in;
      bit_nx   = '0;
      dout_nx  = ~buttons_in[BTN_A];
      if (latch_rise) begin
        ovr_nx = 1'b0;
      end
    end else if (latch_fall) begin
      state_nx = PAD_SHIFT;
      bit_nx   = '0;
      cnt_nx   = frame_count + 8'd1;
      dout_nx  = sr[0];
    end else begin
      case (state)
        PAD_SHIFT: begin
          dout_nx = sr[0];
          if (pulse_rise) begin
            sr_nx  = {sr[1:NES_BITS-1], FILL_BIT};
            bit_nx = bit_index + 4'd1;
            if (bit_index == LAST_IDX) begin
              done_nx  = 1'b1;
              state_nx = PAD_DRAINED;
            end
          end
        end
        PAD_DRAINED: begin
          dout_nx = FILL_BIT;
          if (pulse_rise) begin
            ovr_nx = 1'b1;
          end
        end
        default: begin
          state_nx = PAD_SHIFT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_pad_responder.sv
// Scoreboard bench for nes_pad_responder: expected serial bits are queued as
// each frame is latched and compared as the console pulses them out.
`timescale 1ns/1ps
module tb_nes_pad_responder;

  localparam int unsigned SYNC = 2;
  localparam logic        FILL = 1'b0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       latch_in = 1'b0;
  logic       pulse_in = 1'b0;
  logic [0:7] buttons_in = '0;
  logic       data_out;
  logic [3:0] bit_index;
  logic       frame_done;
  logic       overrun;
  logic [7:0] frame_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_seen = 0;
  logic [7:0] exp_cnt = '0;
  logic exp_q[$];

  nes_pad_responder #(.SYNC_STAGES(SYNC), .FILL_BIT(FILL)) dut (
    .clk         (clk),
    .rst         (rst),
    .latch_in    (latch_in),
    .pulse_in    (pulse_in),
    .buttons_in  (buttons_in),
    .data_out    (data_out),
    .bit_index   (bit_index),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) done_seen++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_settle();
    repeat (SYNC + 4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_pulse();
    @(posedge clk); #2 pulse_in = 1'b1;
    wait_settle();
    @(posedge clk); #2 pulse_in = 1'b0;
    wait_settle();
  endtask

  task automatic start_frame(input logic [0:7] b, input int unsigned hold);
    @(posedge clk); #2 buttons_in = b; latch_in = 1'b1;
    repeat (hold) @(posedge clk);
    #2 latch_in = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    wait_settle();
  endtask

  task automatic push_frame(input logic [0:7] b);
    for (int i = 0; i < 8; i++) exp_q.push_back(~b[i]);
  endtask

  task automatic test_reset();
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({data_out, bit_index, frame_done, overrun, frame_count} !== {1'b1, 4'd0, 1'b0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_hold: got dout=%b idx=%0d done=%b ovr=%b cnt=%0d, want 1/0/0/0/0",
               data_out, bit_index, frame_done, overrun, frame_count);
    end
    @(posedge clk); #2 rst = 1'b1;
    wait_settle(); wait_settle();
    n_checks++;
    if ({data_out, bit_index, overrun, frame_count} !== {1'b1, 4'd0, 1'b0, 8'd0} || done_seen != 0) begin
      n_fail++;
      $display("FAIL reset_release: got dout=%b idx=%0d ovr=%b cnt=%0d dones=%0d, want 1/0/0/0/0",
               data_out, bit_index, overrun, frame_count, done_seen);
    end
  endtask

  task automatic test_basic();
    logic [0:7] b;
    logic exp;
    int base;
    b = 8'b1001_0000;
    base = done_seen;
    start_frame(b, 1200);
    push_frame(b);
    exp = exp_q.pop_front();
    n_checks++;
    if (data_out !== exp) begin
      n_fail++; $display("FAIL basic_bit0: got %b want %b", data_out, exp);
    end
    // pin edge to data_out takes exactly SYNC+2 clocks
    @(posedge clk); #1 pulse_in = 1'b1;
    repeat (SYNC + 1) @(posedge clk);
    #1;
    n_checks++;
    if (data_out !== exp) begin
      n_fail++; $display("FAIL latency_early: got %b want %b", data_out, exp);
    end
    @(posedge clk); #1;
    exp = exp_q.pop_front();
    n_checks++;
    if (data_out !== exp) begin
      n_fail++; $display("FAIL latency_bit1: got %b want %b", data_out, exp);
    end
    #1 pulse_in = 1'b0;
    wait_settle();
    for (int i = 2; i < 8; i++) begin
      drive_pulse();
      exp = exp_q.pop_front();
      n_checks++;
      if (data_out !== exp) begin
        n_fail++; $display("FAIL basic_bit%0d: got %b want %b", i, data_out, exp);
      end
    end
    drive_pulse();
    n_checks++;
    if (done_seen - base != 1 || bit_index !== 4'd8 || frame_count !== exp_cnt || data_out !== FILL) begin
      n_fail++;
      $display("FAIL basic_end: got dones=%0d idx=%0d cnt=%0d dout=%b, want 1/8/%0d/%b",
               done_seen - base, bit_index, frame_count, data_out, exp_cnt, FILL);
    end
  endtask

  task automatic test_overrun();
    logic [0:7] b;
    logic exp;
    int base;
    b = 8'b0110_1001;
    base = done_seen;
    start_frame(b, 20);
    push_frame(b);
    exp_q.push_back(FILL);
    exp_q.push_back(FILL);
    exp = exp_q.pop_front();
    n_checks++;
    if (data_out !== exp) begin
      n_fail++; $display("FAIL ovr_bit0: got %b want %b", data_out, exp);
    end
    for (int p = 1; p < 10; p++) begin
      drive_pulse();
      exp = exp_q.pop_front();
      n_checks++;
      if (data_out !== exp) begin
        n_fail++; $display("FAIL ovr_bit%0d: got %b want %b", p, data_out, exp);
      end
    end
    drive_pulse();
    n_checks++;
    if (overrun !== 1'b1 || bit_index !== 4'd8 || done_seen - base != 1 || data_out !== FILL) begin
      n_fail++;
      $display("FAIL ovr_set: got ovr=%b idx=%0d dones=%0d dout=%b, want 1/8/1/%b",
               overrun, bit_index, done_seen - base, data_out, FILL);
    end
    @(posedge clk); #2 latch_in = 1'b1;
    wait_settle();
    n_checks++;
    if (overrun !== 1'b0 || bit_index !== 4'd0) begin
      n_fail++; $display("FAIL ovr_clear: got ovr=%b idx=%0d, want 0/0", overrun, bit_index);
    end
  endtask

  task automatic test_snapshot();
    logic [0:7] b;
    logic exp;
    b = 8'b1100_0011;
    start_frame(b, 20);
    push_frame(b);
    buttons_in = 8'b0011_1100;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) drive_pulse();
      exp = exp_q.pop_front();
      n_checks++;
      if (data_out !== exp) begin
        n_fail++; $display("FAIL snap_bit%0d: got %b want %b", i, data_out, exp);
      end
    end
  endtask

  task automatic test_abort();
    logic [0:7] b;
    int base;
    b = 8'b0101_0101;
    base = done_seen;
    start_frame(b, 20);
    repeat (3) drive_pulse();
    @(posedge clk); #2 buttons_in = 8'b1010_1010; latch_in = 1'b1;
    wait_settle();
    n_checks++;
    if (done_seen != base || bit_index !== 4'd0 || data_out !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: got dones=%0d idx=%0d dout=%b ovr=%b, want 0/0/0/0",
               done_seen - base, bit_index, data_out, overrun);
    end
    @(posedge clk); #2 buttons_in = 8'b0010_1010;
    wait_settle();
    n_checks++;
    if (data_out !== 1'b1) begin
      n_fail++; $display("FAIL abort_follow: got %b want 1", data_out);
    end
  endtask

  task automatic test_reset_mid();
    logic [0:7] b;
    logic exp;
    int base;
    start_frame(8'b1111_0000, 20);
    repeat (3) drive_pulse();
    base = done_seen;
    @(posedge clk); #3 rst = 1'b0;
    #1;
    n_checks++;
    if ({data_out, bit_index, overrun, frame_count} !== {1'b1, 4'd0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL rst_mid: got dout=%b idx=%0d ovr=%b cnt=%0d, want 1/0/0/0",
               data_out, bit_index, overrun, frame_count);
    end
    exp_cnt = '0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    wait_settle();
    b = 8'b0000_1101;
    start_frame(b, 20);
    push_frame(b);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) drive_pulse();
      exp = exp_q.pop_front();
      n_checks++;
      if (data_out !== exp) begin
        n_fail++; $display("FAIL rst_frame_bit%0d: got %b want %b", i, data_out, exp);
      end
    end
    drive_pulse();
    n_checks++;
    if (frame_count !== 8'd1 || done_seen - base != 1) begin
      n_fail++;
      $display("FAIL rst_frame_end: got cnt=%0d dones=%0d, want 1/1", frame_count, done_seen - base);
    end
  endtask

  task automatic test_wrap_coincident();
    for (int k = 0; k < 255; k++) start_frame(8'h00, 4);
    n_checks++;
    if (frame_count !== exp_cnt || frame_count !== 8'd0) begin
      n_fail++; $display("FAIL wrap: got cnt=%0d want %0d", frame_count, exp_cnt);
    end
    repeat (8) drive_pulse();
    buttons_in = 8'b1000_0000;
    @(posedge clk); #2 latch_in = 1'b1; pulse_in = 1'b1;
    wait_settle();
    n_checks++;
    if (overrun !== 1'b0 || bit_index !== 4'd0 || data_out !== 1'b0) begin
      n_fail++;
      $display("FAIL coincident: got ovr=%b idx=%0d dout=%b, want 0/0/0", overrun, bit_index, data_out);
    end
    @(posedge clk); #2 pulse_in = 1'b0;
    wait_settle();
    drive_pulse();
    n_checks++;
    if (overrun !== 1'b0 || bit_index !== 4'd0) begin
      n_fail++; $display("FAIL pulse_in_load: got ovr=%b idx=%0d, want 0/0", overrun, bit_index);
    end
    @(posedge clk); #2 latch_in = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    wait_settle();
    n_checks++;
    if (frame_count !== exp_cnt) begin
      n_fail++; $display("FAIL post_wrap_cnt: got %0d want %0d", frame_count, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_snapshot();
    test_abort();
    test_reset_mid();
    test_wrap_coincident();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
